uart_pkt_assembler: RTL and testbench
=====================================

# uart_pkt_assembler

Byte-to-packet assembler between the byte-level UART receiver and the loopback/packet logic. It collects `PKT_BYTES` received characters into one 128-bit word and emits a one-cycle done pulse with the word held stable, matching the `recv_done`/`recv_data` contract the loop stage consumes. Partial packets are aborted on a framing error or an inter-byte idle timeout, so a dropped character never shifts every following packet.

## Interface
Parameters:
- `CLK_FREQ`, 50000000: system clock frequency in Hz.
- `UART_BPS`, 115200: line rate; sets the timeout unit.
- `PKT_BYTES`, 16: bytes per packet; `8*PKT_BYTES` must be ≤ 128.
- `TIMEOUT_CHARS`, 4: inter-byte idle limit, in character times (10 bits each).

Ports:
- `sys_clk`  in  1  system clock. One clock domain only.
- `sys_rst`  in  1  asynchronous, active-high reset.
- `byte_valid`  in  1  one-cycle strobe: a received character is on `byte_data`.
- `byte_data`  in  8  received character; sampled only when `byte_valid`=1.
- `byte_err`  in  1  framing error for this character; qualified by `byte_valid`.
- `pkt_done`  out  1  one-cycle pulse: `pkt_data` holds a new packet.
- `pkt_data`  out  128  assembled packet. Byte k sits at `[8k+7:8k]`; the first byte received is at `[7:0]`. Bits above `8*PKT_BYTES` are 0.
- `pkt_busy`  out  1  high while a partial packet is being collected.
- `abort_cnt`  out  8  saturating count of aborted or dropped packets.

## Operation
- Timeout constant: `TO_CYC = TIMEOUT_CHARS*10*(CLK_FREQ/UART_BPS)`, using integer division. Defaults give 4*10*434 = 17360 cycles.
- FSM states are IDLE and COLLECT.
- IDLE:
  - `byte_valid`=1 and `byte_err`=0: write the byte to slot 0, set `idx`=1, clear the timer, go to COLLECT.
  - `byte_valid`=1 and `byte_err`=1: drop the byte, increment `abort_cnt`, stay in IDLE.
- COLLECT:
  - Timer increments every cycle and clears on each accepted byte.
  - Good byte: write it to slot `idx`. If `idx`=`PKT_BYTES-1`, copy the buffer plus this byte into `pkt_data`, set `pkt_done`, and go to IDLE. Otherwise increment `idx`.
  - `byte_err` with `byte_valid`: abort the partial packet, increment `abort_cnt`, go to IDLE. The bad byte is discarded.
  - Timer reaches `TO_CYC-1` with no byte: abort, increment `abort_cnt`, go to IDLE.
- Abort rules:
  - On any abort, `pkt_data` keeps its previous value and `pkt_done` does not pulse.
  - The working buffer is not cleared. Stale slots are always overwritten before the next copy.
  - If a byte arrives in the same cycle the timer expires, the byte wins: it is accepted and the timer clears.
- `abort_cnt` saturates at 255 and never wraps.
- `pkt_busy` = (state == COLLECT).

## Timing
- Reset values: state IDLE, `idx`=0, timer=0, `pkt_done`=0, `pkt_data`=0, `pkt_busy`=0, `abort_cnt`=0.
- Latency: last byte strobed in cycle N gives `pkt_done`=1 and new `pkt_data` in cycle N+1, both registered.
- `pkt_data` then holds until the next completed packet.
- `pkt_done` is never high for two consecutive cycles. The minimum spacing between pulses is `PKT_BYTES` strobes.
- A strobe in cycle N+1 (same cycle as `pkt_done`) is accepted as byte 0 of the next packet. There are no dead cycles.
- No backpressure: the downstream stage must consume `pkt_data` before the next `pkt_done`.
- Reset asserted mid-packet discards the partial packet immediately. `abort_cnt` is not incremented for it.

## Structure
- The shared package holds `PKT_W`=128, `BYTE_W`=8, the FSM state encoding, and the `TO_CYC` computation function.
- One natural sub-module: `idle_timer`, a loadable counter with `clear` and `expire` outputs, parameterised by `TO_CYC`.
- Everything else is flat in this module.

## Test plan
- Send 16 good bytes 0x00..0x0F at 434-cycle spacing:
  - `pkt_done` pulses once, one cycle after the last strobe.
  - `pkt_data` = 0x0F0E…0100.
  - `abort_cnt`=0.
- Send 5 bytes, then idle for 17360 cycles:
  - Abort happens; `abort_cnt`=1; no `pkt_done`; `pkt_data` unchanged.
  - Then send 16 bytes 0xA0..0xAF: `pkt_data` = 0xAFAE…A1A0.
- Set `byte_err`=1 on byte 7 of 16:
  - Abort happens and `abort_cnt` increments.
  - The next 16 good bytes form a clean packet.
- Send two packets back-to-back, with byte 0 of packet 2 strobed in the `pkt_done` cycle:
  - Both packets complete.
  - Packet 2 byte 0 sits at `[7:0]`.
- Assert `sys_rst` after byte 9:
  - All outputs return to their reset values.
  - 16 new bytes then complete normally.
- Send 300 error strobes while in IDLE: `abort_cnt` saturates at 255.

Source files
------------

// File: rtl/uart_pkt_assembler_pkg.sv
// Shared definitions for the UART byte-to-packet assembler.
//   PKT_W / BYTE_W : packet and character widths
//   state_e        : assembler FSM state encoding
//   calc_to_cyc()  : inter-byte idle limit in system clock cycles
package uart_pkt_assembler_pkg;

  localparam int PKT_W  = 128;
  localparam int BYTE_W = 8;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_e;

  // One character is 10 bit times (start + 8 data + stop).
  function automatic int calc_to_cyc(input int clk_freq, input int uart_bps,
                                     input int timeout_chars);
    return timeout_chars * 10 * (clk_freq / uart_bps);
  endfunction

endpackage

// File: rtl/uart_pkt_assembler_idle_timer.sv
// Inter-byte idle timer for the packet assembler.
//   sys_clk, sys_rst : clock, async active-high reset
//   en               : count while high (assembler is collecting)
//   clear            : reload the full idle window (a byte was accepted)
//   expire           : high during the cycle that ends the TO_CYC-cycle window
// Implemented as a down-counter: a reload at edge e gives expire in the cycle
// that ends with edge e+TO_CYC, i.e. the same cycle an up-counter cleared at
// edge e would show TO_CYC-1.
module idle_timer #(
  parameter int TO_CYC = 17360
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic en,
  input  logic clear,
  output logic expire
);

  localparam int CNT_W = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TO_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = LOAD_VAL;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = en && (cnt_q == '0);

endmodule

// File: rtl/uart_pkt_assembler.sv
// Collects PKT_BYTES received UART characters into one packet word and
// presents it with a one-cycle done pulse. Partial packets are dropped on a
// framing error or an inter-byte idle timeout.
//   sys_clk, sys_rst : clock, async active-high reset
//   byte_valid       : one-cycle strobe, character on byte_data
//   byte_data[7:0]   : received character
//   byte_err         : framing error for the strobed character
//   pkt_done         : one-cycle pulse, pkt_data holds a new packet
//   pkt_data[127:0]  : packet, first byte at [7:0]
//   pkt_busy         : partial packet in progress
//   abort_cnt[7:0]   : saturating count of aborted/dropped packets
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no partial packet; next good byte goes to slot 0
// ST_COLLECT | slots 0..idx-1 filled; idle timer running
module uart_pkt_assembler
  import uart_pkt_assembler_pkg::*;
#(
  parameter int CLK_FREQ      = 50000000,
  parameter int UART_BPS      = 115200,
  parameter int PKT_BYTES     = 16,
  parameter int TIMEOUT_CHARS = 4
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               byte_valid,
  input  logic [BYTE_W-1:0]  byte_data,
  input  logic               byte_err,
  output logic               pkt_done,
  output logic [PKT_W-1:0]   pkt_data,
  output logic               pkt_busy,
  output logic [7:0]         abort_cnt
);

  localparam int TO_CYC = calc_to_cyc(CLK_FREQ, UART_BPS, TIMEOUT_CHARS);
  localparam int IDX_W  = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_BYTES - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [PKT_W-1:0]  buf_q, buf_d;
  logic [PKT_W-1:0]  pkt_data_q, pkt_data_d;
  logic              pkt_done_q, pkt_done_d;
  logic [7:0]        abort_cnt_q, abort_cnt_d;

  logic              good_byte, bad_byte;
  logic              tmr_en, tmr_clear, tmr_expire;
  logic              abort;
  logic [IDX_W-1:0]  cur_idx;

  assign good_byte = byte_valid && !byte_err;
  assign bad_byte  = byte_valid && byte_err;
  assign tmr_en    = (state_q == ST_COLLECT);

  idle_timer #(
    .TO_CYC (TO_CYC)
  ) u_idle_timer (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .en      (tmr_en),
    .clear   (tmr_clear),
    .expire  (tmr_expire)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    buf_d       = buf_q;
    pkt_data_d  = pkt_data_q;
    pkt_done_d  = 1'b0;
    abort_cnt_d = abort_cnt_q;
    tmr_clear   = 1'b0;
    abort       = 1'b0;
    // IDLE always writes slot 0, so both states share the byte path.
    cur_idx     = (state_q == ST_IDLE) ? '0 : idx_q;

    // A good byte takes priority over a timer expiring in the same cycle.
    if (good_byte) begin
      buf_d[{cur_idx, 3'b000} +: BYTE_W] = byte_data;
      tmr_clear = 1'b1;
      if (cur_idx == LAST_IDX) begin
        pkt_data_d = buf_d;
        pkt_done_d = 1'b1;
        idx_d      = '0;
        state_d    = ST_IDLE;
      end else begin
        idx_d   = cur_idx + 1'b1;
        state_d = ST_COLLECT;
      end
    end else if (bad_byte || (tmr_expire && (state_q == ST_COLLECT))) begin
      abort   = 1'b1;
      idx_d   = '0;
      state_d = ST_IDLE;
    end

    if (abort && (abort_cnt_q != 8'hFF)) begin
      abort_cnt_d = abort_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      buf_q       <= '0;
      pkt_data_q  <= '0;
      pkt_done_q  <= 1'b0;
      abort_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      buf_q       <= buf_d;
      pkt_data_q  <= pkt_data_d;
      pkt_done_q  <= pkt_done_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end

  assign pkt_done  = pkt_done_q;
  assign pkt_data  = pkt_data_q;
  assign pkt_busy  = (state_q == ST_COLLECT);
  assign abort_cnt = abort_cnt_q;

endmodule

// File: tb/tb_uart_pkt_assembler.sv
module tb_uart_pkt_assembler;

  localparam int PKT_BYTES = 16;
  localparam int TO_CYC    = 4 * 10 * (50000000 / 115200);

  logic         sys_clk = 1'b0;
  logic         sys_rst;
  logic         byte_valid;
  logic [7:0]   byte_data;
  logic         byte_err;
  logic         pkt_done;
  logic [127:0] pkt_data;
  logic         pkt_busy;
  logic [7:0]   abort_cnt;

  always #5 sys_clk = ~sys_clk;

  uart_pkt_assembler #(
    .CLK_FREQ      (50000000),
    .UART_BPS      (115200),
    .PKT_BYTES     (PKT_BYTES),
    .TIMEOUT_CHARS (4)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_err   (byte_err),
    .pkt_done   (pkt_done),
    .pkt_data   (pkt_data),
    .pkt_busy   (pkt_busy),
    .abort_cnt  (abort_cnt)
  );

  typedef struct {
    logic [127:0] data;
    longint       edge_n;
  } exp_t;

  exp_t         exp_q[$];
  int           errors = 0;
  int           checks = 0;
  longint       drv_cyc = 0;

  // Reference model: the partial packet as a byte queue plus the edge index
  // of the last accepted byte; a packet dies once more than TO_CYC edges
  // pass without a byte.
  logic [7:0]   part[$];
  longint       last_edge = 0;
  int           m_abort = 0;
  logic [127:0] m_last_pkt = '0;
  logic         prev_done = 1'b0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
    drv_cyc++;
  endtask

  function automatic void model_abort();
    if (m_abort < 255) m_abort++;
    part.delete();
  endfunction

  function automatic void model_strobe(input logic [7:0] d, input bit err);
    longint e = drv_cyc;
    logic [127:0] w;
    if (part.size() > 0 && e > last_edge + TO_CYC) model_abort();
    if (err) begin
      model_abort();
    end else begin
      part.push_back(d);
      last_edge = e;
      if (part.size() == PKT_BYTES) begin
        w = '0;
        for (int k = 0; k < PKT_BYTES; k++) w[8*k +: 8] = part[k];
        exp_q.push_back('{data: w, edge_n: e});
        m_last_pkt = w;
        part.delete();
      end
    end
  endfunction

  task automatic send(input logic [7:0] d, input bit err, input int gap);
    repeat (gap) step();
    model_strobe(d, err);
    byte_valid = 1'b1;
    byte_data  = d;
    byte_err   = err;
    step();
    byte_valid = 1'b0;
    byte_err   = 1'b0;
    byte_data  = 8'($urandom);
  endtask

  task automatic checkpoint(input string name);
    if (part.size() > 0 && (drv_cyc - 1) >= last_edge + TO_CYC) model_abort();
    check({name, " busy"},  {127'd0, pkt_busy}, {127'd0, part.size() > 0});
    check({name, " abort"}, {120'd0, abort_cnt}, 128'(m_abort));
    check({name, " data"},  pkt_data, m_last_pkt);
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge sys_clk) begin
    exp_t x;
    if (sys_rst) begin
      prev_done = 1'b0;
    end else begin
      if (pkt_done) begin
        check("done_not_double", {127'd0, prev_done}, 128'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got data %h expected no packet", pkt_data);
        end else begin
          x = exp_q.pop_front();
          check("pkt_data", pkt_data, x.data);
          check("pkt_latency_edge", 128'(drv_cyc - 1), 128'(x.edge_n));
        end
      end
      prev_done = pkt_done;
    end
  end

  initial begin
    sys_rst    = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    byte_err   = 1'b0;
    repeat (3) step();
    check("reset_done", {127'd0, pkt_done}, 128'd0);
    sys_rst = 1'b0;
    step();
    checkpoint("reset");

    // 16 bytes at one-character spacing
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0, (i == 0) ? 0 : 433);
    step();
    checkpoint("pkt_seq");
    check("pkt_seq_literal", pkt_data, 128'h0F0E0D0C0B0A09080706050403020100);

    // 5 bytes then idle timeout; one cycle short of expiry stays busy
    for (int i = 0; i < 5; i++) send(8'($urandom), 1'b0, $urandom_range(0, 20));
    repeat (TO_CYC - 1) step();
    checkpoint("timeout_minus1");
    step();
    checkpoint("timeout");
    for (int i = 0; i < 16; i++) send(8'(8'hA0 + i), 1'b0, $urandom_range(0, 5));
    step();
    checkpoint("after_timeout");
    check("a0_literal", pkt_data, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0);

    // framing error on byte 7
    for (int i = 0; i < 8; i++) send(8'($urandom), (i == 7), $urandom_range(0, 3));
    checkpoint("err_byte7");
    for (int i = 0; i < 16; i++) send(8'($urandom), 1'b0, $urandom_range(0, 3));
    step();
    checkpoint("after_err");

    // back-to-back packets: pkt2 byte 0 lands in the done cycle
    for (int i = 0; i < 32; i++) send(8'($urandom), 1'b0, 0);
    step();
    checkpoint("back_to_back");

    // byte exactly at the expiry cycle wins
    for (int i = 0; i < 3; i++) send(8'($urandom), 1'b0, 0);
    send(8'($urandom), 1'b0, TO_CYC - 1);
    checkpoint("byte_wins");
    for (int i = 0; i < 12; i++) send(8'($urandom), 1'b0, 0);
    step();
    checkpoint("byte_wins_pkt");

    // byte one cycle after expiry starts a fresh packet
    for (int i = 0; i < 2; i++) send(8'($urandom), 1'b0, 0);
    send(8'($urandom), 1'b0, TO_CYC);
    checkpoint("late_byte");
    for (int i = 0; i < 15; i++) send(8'($urandom), 1'b0, $urandom_range(0, 2));
    step();
    checkpoint("late_byte_pkt");

    // random traffic with occasional framing errors
    for (int i = 0; i < 100; i++)
      send(8'($urandom), ($urandom_range(0, 39) == 0), $urandom_range(0, 30));
    step();
    checkpoint("random");

    // reset in the middle of a packet
    for (int i = 0; i < 16; i++) send(8'($urandom), 1'b0, 0);
    for (int i = 0; i < 9; i++) send(8'($urandom), 1'b0, 0);
    sys_rst = 1'b1;
    #2;
    part.delete();
    m_abort    = 0;
    m_last_pkt = '0;
    check("rst_mid_done", {127'd0, pkt_done}, 128'd0);
    checkpoint("rst_mid");
    step();
    sys_rst = 1'b0;
    step();
    for (int i = 0; i < 16; i++) send(8'($urandom), 1'b0, $urandom_range(0, 4));
    step();
    checkpoint("after_rst");

    // abort counter saturation
    for (int i = 0; i < 300; i++) send(8'($urandom), 1'b1, 0);
    step();
    checkpoint("saturate");
    check("saturate_literal", {120'd0, abort_cnt}, 128'd255);

    repeat (3) step();
    check("scoreboard_empty", 128'(exp_q.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
